// File: rtl/oddr_tx_pkg.sv
// rtl/oddr_tx_pkg.sv - shared state encoding and preamble pair for oddr_shift_tx
package oddr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2
  } tx_state_e;

  localparam logic [1:0] SYNC = 2'b00;

endpackage

// File: rtl/oddr_shift_tx.sv
// rtl/oddr_shift_tx.sv - word-to-pair serializer feeding an ODDR, MSB first
// Optional SYNC preamble pair before every word: define ODDR_SHIFT_TX_PREAMBLE_EN.
module oddr_shift_tx #(
  parameter int   W    = 16,
  parameter logic IDLE = 1'b1
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic         d_ready,
  output logic [1:0]   q,
  output logic         busy
);

  localparam int             CW        = (W / 2 > 1) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0]  LAST      = CW'(W / 2 - 1);
  localparam logic [1:0]     IDLE_PAIR = {IDLE, IDLE};

  oddr_tx_pkg::tx_state_e state;
  logic [CW-1:0]          cnt;
  logic [W-1:0]           sh;
  logic                   load;

  // q[0] is the bit sent on the rising edge, so the MSB of each pair goes there.
  function automatic logic [1:0] top_pair(input logic [W-1:0] w);
    return {w[W-2], w[W-1]};
  endfunction

  // A new word may start from idle or in the final pair cycle of the current word.
  always_comb begin
    load = 1'b0;
    if (d_valid && d_ready &&
        (state == oddr_tx_pkg::IDLE || (state == oddr_tx_pkg::SHIFT && cnt == LAST)))
      load = 1'b1;
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state   <= oddr_tx_pkg::IDLE;
      cnt     <= '0;
      sh      <= '0;
      q       <= IDLE_PAIR;
      busy    <= 1'b0;
      d_ready <= 1'b0;
    end else if (load) begin
`ifdef ODDR_SHIFT_TX_PREAMBLE_EN
      state   <= oddr_tx_pkg::PRE;
      q       <= oddr_tx_pkg::SYNC;
      sh      <= d;
`else
      state   <= oddr_tx_pkg::SHIFT;
      q       <= top_pair(d);
      sh      <= d << 2;
`endif
      cnt     <= '0;
      busy    <= 1'b1;
      d_ready <= 1'b0;
    end else if (state == oddr_tx_pkg::PRE) begin
      state   <= oddr_tx_pkg::SHIFT;
      q       <= top_pair(sh);
      sh      <= sh << 2;
      cnt     <= '0;
      busy    <= 1'b1;
      d_ready <= 1'b0;
    end else if (state == oddr_tx_pkg::SHIFT && cnt != LAST) begin
      q       <= top_pair(sh);
      sh      <= sh << 2;
      cnt     <= cnt + 1'b1;
      busy    <= 1'b1;
      // Ready is registered so it is already high during the last pair.
      d_ready <= (cnt + 1'b1 == LAST);
    end else begin
      state   <= oddr_tx_pkg::IDLE;
      q       <= IDLE_PAIR;
      cnt     <= '0;
      busy    <= 1'b0;
      d_ready <= 1'b1;
    end
  end

endmodule
